// File: rtl/pooling_layers_pkg.sv
// pooling_layers_pkg: helpers shared by the pooling pipeline stages
// padded_dim(n, p): image dimension n grown by p pad elements on each side
package pooling_layers_pkg;
    function automatic int padded_dim(input int n, input int p);
        return n + 2 * p;
    endfunction
endpackage

// File: rtl/padding_stream_skid_buffer.sv
// skid_buffer: 2-entry registered valid/ready buffer
// in_data/in_valid/in_ready    upstream handshake (in_ready comes straight from a register)
// out_data/out_valid/out_ready downstream handshake, out_data held while stalled
module skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] sk_data;
    logic             sk_valid;
    assign in_ready = !sk_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sk_data   <= '0;
            sk_valid  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (sk_valid) begin
                out_data  <= sk_data;
                out_valid <= 1'b1;
                sk_valid  <= 1'b0;
            end else begin
                out_valid <= in_valid;
                out_data  <= in_valid ? in_data : out_data;
            end
        end else if (in_valid && in_ready) begin
            sk_data  <= in_data;
            sk_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/padding_stream.sv
// padding_stream: inserts PAD_VALUE border beats around a raster-order frame
// data_in/data_in_valid/data_in_ready        unpadded beats, consumed only on interior positions
// data_out/data_out_valid/data_out_ready     padded beats, registered through a skid buffer
// data_out_last                              final beat of each padded frame
module padding_stream
    import pooling_layers_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    IMG_WIDTH      = 4,
    parameter int                    IMG_HEIGHT     = 3,
    parameter int                    CHANNELS       = 2,
    parameter int                    PADDING_WIDTH  = 1,
    parameter int                    PADDING_HEIGHT = 1,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last
);
    localparam int OW = padded_dim(IMG_WIDTH, PADDING_WIDTH);
    localparam int OH = padded_dim(IMG_HEIGHT, PADDING_HEIGHT);
    localparam int CW = $clog2(CHANNELS) + 1;
    localparam int XW = $clog2(OW) + 1;
    localparam int YW = $clog2(OH) + 1;
    logic [CW-1:0]       c;
    logic [XW-1:0]       x, x_rel;
    logic [YW-1:0]       y, y_rel;
    logic                c_end, x_end, y_end, interior;
    logic                gen_valid, gen_last, sk_ready, adv;
    logic [DATA_WIDTH-1:0] gen_data;
    logic [DATA_WIDTH:0]   sk_out;
    // Positions left/above the interior wrap to large values, so one unsigned
    // compare per axis covers both borders (counter widths leave enough headroom).
    assign x_rel         = x - XW'(PADDING_WIDTH);
    assign y_rel         = y - YW'(PADDING_HEIGHT);
    assign interior      = (x_rel < XW'(IMG_WIDTH)) && (y_rel < YW'(IMG_HEIGHT));
    assign c_end         = c == CW'(CHANNELS - 1);
    assign x_end         = x == XW'(OW - 1);
    assign y_end         = y == YW'(OH - 1);
    assign gen_last      = c_end && x_end && y_end;
    assign gen_data      = interior ? data_in : PAD_VALUE;
    assign gen_valid     = interior ? data_in_valid : 1'b1;
    assign adv           = gen_valid && sk_ready;
    assign data_in_ready = interior && sk_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '0;
            x <= '0;
            y <= '0;
        end else if (adv) begin
            c <= c_end ? '0 : c + 1'b1;
            if (c_end) x <= x_end ? '0 : x + 1'b1;
            if (c_end && x_end) y <= y_end ? '0 : y + 1'b1;
        end
    end
    skid_buffer #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({gen_last, gen_data}),
        .in_valid (gen_valid),
        .in_ready (sk_ready),
        .out_data (sk_out),
        .out_valid(data_out_valid),
        .out_ready(data_out_ready)
    );
    assign {data_out_last, data_out} = sk_out;
endmodule

// File: tb/tb_padding_stream.sv
// tb_padding_stream: directed checks of padding_stream in four configurations
module tb_padding_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din[4];
    logic        dinv[4];
    logic        dinr[4];
    logic [31:0] dout[4];
    logic        doutv[4];
    logic        doutr[4];
    logic        doutl[4];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];
    int          fin_c[$];
    logic [31:0] exp_d[$];
    int          first_rdy;

    always #5 clk = ~clk;

    padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(1),
                     .PADDING_WIDTH(1), .PADDING_HEIGHT(1), .PAD_VALUE(32'h0)) u0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .data_in_valid(dinv[0]), .data_in_ready(dinr[0]),
        .data_out(dout[0]), .data_out_valid(doutv[0]), .data_out_ready(doutr[0]), .data_out_last(doutl[0]));
    padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(2),
                     .PADDING_WIDTH(1), .PADDING_HEIGHT(0), .PAD_VALUE(32'h0)) u1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .data_in_valid(dinv[1]), .data_in_ready(dinr[1]),
        .data_out(dout[1]), .data_out_valid(doutv[1]), .data_out_ready(doutr[1]), .data_out_last(doutl[1]));
    padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(3), .CHANNELS(2),
                     .PADDING_WIDTH(0), .PADDING_HEIGHT(0), .PAD_VALUE(32'h0)) u2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .data_in_valid(dinv[2]), .data_in_ready(dinr[2]),
        .data_out(dout[2]), .data_out_valid(doutv[2]), .data_out_ready(doutr[2]), .data_out_last(doutl[2]));
    padding_stream #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNELS(1),
                     .PADDING_WIDTH(1), .PADDING_HEIGHT(1), .PAD_VALUE(32'h8000_0000)) u3 (
        .clk(clk), .rst(rst), .data_in(din[3]), .data_in_valid(dinv[3]), .data_in_ready(dinr[3]),
        .data_out(dout[3]), .data_out_valid(doutv[3]), .data_out_ready(doutr[3]), .data_out_last(doutl[3]));

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int s, input int n_out, input int npx, input bit rnd, input int stop_at);
        int   idx = 0;
        int   cyc = 0;
        logic hv = 1'b0;
        logic hl = 1'b0;
        logic [31:0] hd = '0;
        got_d.delete();
        got_l.delete();
        got_c.delete();
        fin_c.delete();
        first_rdy = -1;
        while (got_d.size() < n_out && got_d.size() != stop_at) begin
            if (cyc > 3000) begin
                chk("timeout", got_d.size(), n_out);
                break;
            end
            if (hv) begin
                chk("stall_valid", {31'b0, doutv[s]}, 32'd1);
                chk("stall_data", dout[s], hd);
                chk("stall_last", {31'b0, doutl[s]}, {31'b0, hl});
            end
            if (dinr[s] && first_rdy < 0) first_rdy = got_d.size() + (doutv[s] ? 1 : 0);
            doutr[s] = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            dinv[s]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            din[s]   = 32'(idx % npx + 1);
            hv = doutv[s] && !doutr[s];
            hd = dout[s];
            hl = doutl[s];
            if (doutv[s] && doutr[s]) begin
                got_d.push_back(dout[s]);
                got_l.push_back(doutl[s]);
                got_c.push_back(cyc);
            end
            if (dinv[s] && dinr[s]) begin
                fin_c.push_back(cyc);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        dinv[s]  = 1'b0;
        doutr[s] = 1'b0;
    endtask

    task automatic cmp(input string t, input int flen);
        for (int k = 0; k < got_d.size(); k++) begin
            chk(t, got_d[k], exp_d[k % exp_d.size()]);
            chk({t, "_last"}, {31'b0, got_l[k]}, {31'b0, k % flen == flen - 1});
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            din[i]   = '0;
            dinv[i]  = 1'b0;
            doutr[i] = 1'b0;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", {31'b0, doutv[i]}, 32'd0);
            chk("rst_data", dout[i], 32'd0);
            chk("rst_last", {31'b0, doutl[i]}, 32'd0);
        end
        chk("rst_in_ready_pad", {31'b0, dinr[0]}, 32'd0);
        chk("rst_in_ready_pad_w", {31'b0, dinr[1]}, 32'd0);
        chk("rst_in_ready_nopad", {31'b0, dinr[2]}, 32'd1);

        exp_d = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
        run(0, 16, 4, 1'b0, -1);
        chk("t1_count", got_d.size(), 16);
        cmp("t1_beat", 16);
        chk("t1_in_ready_first", first_rdy, 5);

        do_reset();
        exp_d = '{0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 5, 6, 7, 8, 0, 0};
        run(1, 16, 8, 1'b0, -1);
        chk("t2_count", got_d.size(), 16);
        cmp("t2_beat", 16);

        do_reset();
        exp_d = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'h8000_0000, 1, 2, 32'h8000_0000,
                  32'h8000_0000, 3, 4, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        run(3, 32, 4, 1'b1, -1);
        chk("t3_count", got_d.size(), 32);
        cmp("t3_beat", 16);

        do_reset();
        exp_d.delete();
        for (int k = 1; k <= 24; k++) exp_d.push_back(32'(k));
        run(2, 24, 24, 1'b0, -1);
        chk("t4_count", got_d.size(), 24);
        cmp("t4_beat", 24);
        if (got_c.size() == 24 && fin_c.size() > 0) begin
            chk("t4_latency", got_c[0] - fin_c[0], 1);
            chk("t4_throughput", got_c[23] - got_c[0], 23);
        end else chk("t4_sizes", got_c.size(), 24);

        do_reset();
        exp_d = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
        run(0, 32, 4, 1'b0, -1);
        chk("t5_count", got_d.size(), 32);
        cmp("t5_beat", 16);
        if (got_c.size() == 32) begin
            chk("t5_no_bubble", got_c[16] - got_c[15], 1);
            chk("t5_span", got_c[31] - got_c[0], 31);
        end

        do_reset();
        run(0, 16, 4, 1'b0, 7);
        chk("t6_partial", got_d.size(), 7);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", {31'b0, doutv[0]}, 32'd0);
        chk("t6_rst_data", dout[0], 32'd0);
        rst = 1'b0;
        run(0, 16, 4, 1'b0, -1);
        chk("t6_count", got_d.size(), 16);
        cmp("t6_beat", 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/padding_stream.md
# padding_stream

Streaming 2-D padding inserter placed directly upstream of the sliding-window stage in the pooling pipeline. Accepts an unpadded IMG_HEIGHT × IMG_WIDTH × CHANNELS frame in raster order (channel fastest, then x, then y). Emits the padded (IMG_HEIGHT+2·PADDING_HEIGHT) × (IMG_WIDTH+2·PADDING_WIDTH) × CHANNELS frame in the same order, inserting PAD_VALUE beats on border positions without consuming input. Output is registered through a skid buffer, so the sliding window sees full throughput with no combinational ready path back to the producer.

## Interface
- DATA_WIDTH, 32, beat width
- IMG_WIDTH, 4, unpadded width in pixels
- IMG_HEIGHT, 3, unpadded height in pixels
- CHANNELS, 2, channels per pixel
- PADDING_WIDTH, 1, pad columns on each of left and right
- PADDING_HEIGHT, 1, pad rows on each of top and bottom
- PAD_VALUE, 0, DATA_WIDTH-bit value emitted on pad positions; set to the most-negative value for max-pooling signed data
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- data_in  in  DATA_WIDTH  unpadded beat
- data_in_valid  in  1  producer valid
- data_in_ready  out  1  accepts data_in this cycle
- data_out  out  DATA_WIDTH  padded beat
- data_out_valid  out  1  data_out valid
- data_out_ready  in  1  consumer ready
- data_out_last  out  1  high on the final beat of a padded frame

## Operation
- Derived: OW = IMG_WIDTH+2·PADDING_WIDTH, OH = IMG_HEIGHT+2·PADDING_HEIGHT. Counters c∈[0,CHANNELS-1], x∈[0,OW-1], y∈[0,OH-1], sized $clog2(max)+1 bits. All compares are unsigned and zero-extended.
- interior = (PADDING_WIDTH ≤ x < PADDING_WIDTH+IMG_WIDTH) && (PADDING_HEIGHT ≤ y < PADDING_HEIGHT+IMG_HEIGHT).
- Generator beat: gen_data = interior ? data_in : PAD_VALUE; gen_valid = interior ? data_in_valid : 1; gen_last = (c==CHANNELS-1 && x==OW-1 && y==OH-1).
- data_in_ready = interior && skid_in_ready. Input is never consumed on a pad position.
- The generator advances only on gen_valid && skid_in_ready. Sequence: c increments; at CHANNELS-1, c→0 and x increments; at OW-1, x→0 and y increments; at the gen_last beat, all counters → 0 and the next frame starts on the next cycle with no idle beat.
- PADDING_WIDTH = PADDING_HEIGHT = 0: the block is a pure registered pass-through.
- Reset values: c=x=y=0, data_out_valid=0, data_out=0, data_out_last=0. data_in_ready = interior at (0,0,0) && skid empty, so it is 0 when any padding exists and 1 when there is none.
- Reset mid-frame drops the partial frame, and the skid contents are discarded. The next accepted input is pixel (0,0,c0) of a new frame.

## Timing
- Latency is 1 cycle from generator handshake to data_out_valid.
- Throughput is 1 beat per cycle while data_out_ready=1 and the producer supplies interior beats with no gaps.
- A pad run of k beats completes in k cycles regardless of data_in_valid.
- skid_in_ready is a register: high when the skid holds ≤1 entry and will not be full.
- data_out and data_out_last are held stable while data_out_valid && !data_out_ready.
- data_out_valid does not drop without a handshake.
- data_in_ready may be high while data_in_valid is low; no transfer occurs in that case.
- The producer must not depend on data_in_ready to raise data_in_valid.

## Structure
- The shared package pooling_layers_pkg holds function padded_dim(n,p) = n+2p. sliding_window uses the same function to size IMG_WIDTH/IMG_HEIGHT, so the two stages cannot disagree.
- One sub-module, skid_buffer #(WIDTH): 2-entry registered valid/ready buffer carrying {last, data}.
- Counter/interior logic lives inline in padding_stream.

## Test plan
- H=W=2, C=1, PW=PH=1, inputs 1,2,3,4, ready=1 → 16 beats 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0. Last high only on beat 16; data_in_ready first high on output beat 6.
- H=W=2, C=2, PW=1, PH=0, inputs 1..8 → 0,0,1,2,3,4,0,0,0,0,5,6,7,8,0,0. Each pad pixel yields two PAD_VALUE beats.
- Same as test 1 with PAD_VALUE=32'h8000_0000 and random data_out_ready (50%) plus random data_in_valid gaps → identical beat sequence, no drops or duplicates, data_out stable while stalled.
- PW=PH=0, H=3, W=4, C=2, 24 inputs → 24 identical outputs, 1-cycle latency, last on beat 24, sustained 1 beat/cycle.
- Two back-to-back frames of test 1 → 32 beats, second frame starts the cycle after the first last, no bubble.
- rst asserted after 7 output beats of test 1 → valid=0 next cycle, then a fresh frame produces the full 16-beat sequence from beat 1.
